// File: rtl/io_unit_pkg.sv
// io_unit package: syscall codes and io state encodings.
// Shared with the controller so SYSCALL decoding agrees on both sides.
package io_unit_pkg;

    // Syscall codes carried in ACC[1:0]
    localparam logic [1:0] SYS_HALT   = 2'd0;
    localparam logic [1:0] SYS_READ   = 2'd1;
    localparam logic [1:0] SYS_WRITE  = 2'd2;
    localparam logic [1:0] SYS_CYCLES = 2'd3;

    // io_unit FSM states
    typedef enum logic [1:0] {
        IO_IDLE  = 2'd0,
        IO_READ  = 2'd1,
        IO_WRITE = 2'd2,
        IO_HALT  = 2'd3
    } io_state_e;

    // Busy whenever the unit is not idle
    function automatic logic io_is_busy(input io_state_e s);
        return s != IO_IDLE;
    endfunction

endpackage

// File: rtl/io_unit_if.sv
// io_unit_if: host input/output valid/ready streams.
// slave = io_unit side, master = host side.
interface io_unit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/io_unit_cycle_counter.sv
// cycle_counter: WIDTH-bit free-running counter, wraps to 0.
// Ports: clock, reset (sync active-low clear), count_o.
module cycle_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] count_o
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign cnt_d   = cnt_q + ONE;
    assign count_o = cnt_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/io_unit.sv
// io_unit: SYSCALL executor (HALT/READ/WRITE/CYCLES) for Sextium III.
// Ports: clock, reset, runio, acc, dr, iobusy, io_result, halted, bus.
module io_unit
    import io_unit_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             runio,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] dr,
    output logic             iobusy,
    output logic [WIDTH-1:0] io_result,
    output logic             halted,
    io_unit_if.slave         bus
);
    io_state_e        state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] odata_q, odata_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             halted_q, halted_d;
    logic             busy_q;
    logic [WIDTH-1:0] cycles;

    cycle_counter #(.WIDTH(WIDTH)) u_cnt (
        .clock   (clock),
        .reset   (reset),
        .count_o (cycles)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        odata_d  = odata_q;
        acc_d    = acc_q;
        halted_d = halted_q;
        unique case (state_q)
            IO_IDLE: begin
                // runio in other states is the controller's
                // IOWAIT continuation and is ignored there
                if (runio) begin
                    unique case (acc[1:0])
                        SYS_HALT: begin
                            state_d  = IO_HALT;
                            halted_d = 1'b1;
                        end
                        SYS_READ: begin
                            state_d = IO_READ;
                        end
                        SYS_WRITE: begin
                            state_d = IO_WRITE;
                            odata_d = dr;
                            // ACC is written back unchanged
                            acc_d   = acc;
                        end
                        SYS_CYCLES: begin
                            result_d = cycles;
                        end
                        default: ;
                    endcase
                end
            end
            IO_READ: begin
                if (bus.in_valid) begin
                    result_d = bus.in_data;
                    state_d  = IO_IDLE;
                end
            end
            IO_WRITE: begin
                if (bus.out_ready) begin
                    result_d = acc_q;
                    state_d  = IO_IDLE;
                end
            end
            IO_HALT: begin
                state_d = IO_HALT;
            end
            default: state_d = IO_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IO_IDLE;
            result_q <= '0;
            odata_q  <= '0;
            acc_q    <= '0;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            odata_q  <= odata_d;
            acc_q    <= acc_d;
            halted_q <= halted_d;
            busy_q   <= io_is_busy(state_d);
        end
    end

    assign iobusy        = busy_q;
    assign io_result     = result_q;
    assign halted        = halted_q;
    assign bus.in_ready  = (state_q == IO_READ);
    assign bus.out_valid = (state_q == IO_WRITE);
    assign bus.out_data  = odata_q;
endmodule

// File: tb/tb_io_unit.sv
// tb_io_unit: directed self-checking bench for io_unit.
// Expected io_result / out words go through scoreboard queues.
module tb_io_unit;
    localparam int W = 16;

    logic         clock;
    logic         reset;
    logic         runio;
    logic [W-1:0] acc;
    logic [W-1:0] dr;
    logic         iobusy;
    logic [W-1:0] io_result;
    logic         halted;

    io_unit_if #(.WIDTH(W)) bus ();

    io_unit #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .runio     (runio),
        .acc       (acc),
        .dr        (dr),
        .iobusy    (iobusy),
        .io_result (io_result),
        .halted    (halted),
        .bus       (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference cycle counter built from the counter's description
    logic [W-1:0] ref_cnt;
    always @(posedge clock) begin
        if (!reset) ref_cnt <= '0;
        else ref_cnt <= ref_cnt + 16'd1;
    end

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] res_q[$];
    logic [W-1:0] out_q[$];

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for completion, then pop the expected result
    task automatic finish_op(input string tag, input int budget);
        logic [W-1:0] e;
        int n;
        n = 0;
        while (iobusy === 1'b1 && n < budget) begin
            if (bus.out_valid && bus.out_ready) begin
                if (out_q.size() > 0) begin
                    e = out_q.pop_front();
                    chk({tag, "_out"}, bus.out_data, e);
                end
            end
            tick();
            n++;
        end
        chk({tag, "_done"}, {15'd0, iobusy}, 16'd0);
        if (res_q.size() > 0) begin
            e = res_q.pop_front();
            chk({tag, "_res"}, io_result, e);
        end else begin
            chk({tag, "_noexp"}, 16'd1, 16'd0);
        end
    endtask

    initial begin
        reset         = 1'b0;
        runio         = 1'b0;
        acc           = '0;
        dr            = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        // reset values
        chk("rst_busy", {15'd0, iobusy}, 16'd0);
        chk("rst_res", io_result, 16'd0);
        chk("rst_halt", {15'd0, halted}, 16'd0);
        chk("rst_inrdy", {15'd0, bus.in_ready}, 16'd0);
        chk("rst_ovld", {15'd0, bus.out_valid}, 16'd0);
        chk("rst_odata", bus.out_data, 16'd0);

        // CYCLES at the 6th edge after release reads 5
        repeat (5) tick();
        runio = 1'b1;
        acc   = 16'h0003;
        res_q.push_back(16'd5);
        tick();
        runio = 1'b0;
        chk("cyc_busy", {15'd0, iobusy}, 16'd0);
        finish_op("cyc5", 4);

        // READ with input already valid
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        runio = 1'b1;
        acc   = 16'h0001;
        res_q.push_back(16'h1234);
        tick();
        chk("rd_inrdy", {15'd0, bus.in_ready}, 16'd1);
        chk("rd_busy", {15'd0, iobusy}, 16'd1);
        tick();
        runio = 1'b0;
        bus.in_valid = 1'b0;
        chk("rd_inrdy0", {15'd0, bus.in_ready}, 16'd0);
        finish_op("rd", 4);

        // WRITE with 3 stall cycles
        runio = 1'b1;
        acc   = 16'h0002;
        dr    = 16'hBEEF;
        res_q.push_back(16'h0002);
        out_q.push_back(16'hBEEF);
        tick();
        acc = 16'h7777;
        dr  = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            chk("wr_ovld", {15'd0, bus.out_valid}, 16'd1);
            chk("wr_odata", bus.out_data, 16'hBEEF);
            chk("wr_busy", {15'd0, iobusy}, 16'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        chk("wr_ovld3", {15'd0, bus.out_valid}, 16'd1);
        finish_op("wr", 4);
        runio = 1'b0;
        bus.out_ready = 1'b0;
        chk("wr_ovld0", {15'd0, bus.out_valid}, 16'd0);
        chk("wr_outq", out_q.size(), 16'd0);

        // Back-to-back: CYCLES accepted right after WRITE completed
        runio = 1'b1;
        acc   = 16'hFF03;
        res_q.push_back(ref_cnt);
        tick();
        runio = 1'b0;
        finish_op("cyc_b2b", 4);

        // in_valid/out_ready while idle are ignored
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hAAAA;
        bus.out_ready = 1'b1;
        tick();
        chk("idle_inrdy", {15'd0, bus.in_ready}, 16'd0);
        chk("idle_res", io_result, res_q.size() == 0 ? io_result : 16'hXXXX);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // HALT with upper acc bits set
        runio = 1'b1;
        acc   = 16'hFFFC;
        tick();
        chk("halt_h", {15'd0, halted}, 16'd1);
        chk("halt_busy", {15'd0, iobusy}, 16'd1);
        acc = 16'h0001;
        bus.in_valid = 1'b1;
        repeat (4) tick();
        chk("halt_h2", {15'd0, halted}, 16'd1);
        chk("halt_busy2", {15'd0, iobusy}, 16'd1);
        chk("halt_inrdy", {15'd0, bus.in_ready}, 16'd0);
        runio = 1'b0;
        bus.in_valid = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        res_q.delete();
        chk("halt_clr_h", {15'd0, halted}, 16'd0);
        chk("halt_clr_b", {15'd0, iobusy}, 16'd0);
        chk("halt_clr_r", io_result, 16'd0);

        // Reset during READ, later in_valid not consumed
        runio = 1'b1;
        acc   = 16'h0001;
        tick();
        runio = 1'b0;
        chk("rdr_inrdy", {15'd0, bus.in_ready}, 16'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rdr_inrdy0", {15'd0, bus.in_ready}, 16'd0);
        chk("rdr_busy", {15'd0, iobusy}, 16'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h5555;
        repeat (2) tick();
        chk("rdr_inrdy1", {15'd0, bus.in_ready}, 16'd0);
        chk("rdr_res", io_result, 16'd0);
        bus.in_valid = 1'b0;

        // Counter wrap: 65537th edge after release samples 0
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (65536) tick();
        runio = 1'b1;
        acc   = 16'h0003;
        res_q.push_back(16'd0);
        tick();
        runio = 1'b0;
        finish_op("wrap", 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/io_unit.md
# io_unit

Executes SYSCALL instructions for the Sextium III core. It consumes the controller's `runio` strobe together with ACC (syscall code) and DR (argument), and performs the selected operation over valid/ready input and output streams. It returns `iobusy` to the controller's IOWAIT state and provides `io_result` for the ACC multiplexer (SELACC_IO). It also latches the halt condition.

## Interface
Parameters:
- WIDTH, 16, data word width (ACC/DR/stream width)

Ports:
- clock  input  1  system clock; all state changes on posedge
- reset  input  1  synchronous, active-low reset; sampled on posedge clock
- runio  input  1  controller request; held high in DECODE(SYSCALL) and in IOWAIT while iobusy
- acc  input  WIDTH  syscall code (ACC value at request)
- dr  input  WIDTH  syscall argument (DR value at request)
- iobusy  output  1  registered; high while an operation is in progress
- io_result  output  WIDTH  result word for ACC, stable while iobusy low
- in_valid  input  1  host input word available
- in_data  input  WIDTH  host input word
- in_ready  output  1  unit accepts input this cycle
- out_valid  output  1  output word presented
- out_data  output  WIDTH  output word
- out_ready  input  1  host accepts output this cycle
- halted  output  1  sticky; HALT syscall executed

## Operation
- States: IDLE, READ, WRITE, HALT.
- Request acceptance: `runio` high in IDLE. Lower 2 bits of `acc` are decoded; upper bits are ignored. `runio` outside IDLE is the controller's continuation and is ignored.
- Code 0, HALT: next state HALT. `iobusy`=1 and `halted`=1 until reset. No other activity.
- Code 1, READ: next state READ, `in_ready`=1. On the first cycle with `in_valid & in_ready`: `io_result`<=`in_data`, next state IDLE.
- Code 2, WRITE: `out_data`<=`dr` latched at acceptance, next state WRITE, `out_valid`=1. On `out_valid & out_ready`: next state IDLE, `io_result`<=`acc` latched at acceptance (ACC preserved).
- Code 3, CYCLES: stays IDLE. `io_result`<= low WIDTH bits of the free-running cycle counter, sampled at acceptance.
- Cycle counter: WIDTH bits, increments every clock, wraps at 2^WIDTH-1 to 0, cleared by reset.
- `iobusy` is registered and equals (state != IDLE).
- `in_ready` is high only in READ. `out_valid` is high only in WRITE. `out_data` holds its value through WRITE and may hold its last value afterwards.

## Timing
- Reset values: state IDLE, `iobusy`=0, `io_result`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `halted`=0, counter 0.
- Request accepted at edge T (runio in IDLE). From T+1, `iobusy` reflects the new state.
- READ/WRITE with partner already ready: transfer occurs in cycle T+1, `iobusy` falls at T+2, `io_result` is valid at T+2. Each stall cycle of the partner adds one cycle of latency.
- CYCLES: `iobusy` stays 0 and `io_result` is valid at T+1. The controller leaves IOWAIT after one cycle.
- `io_result` changes only at completion of an accepted operation. It is held until the next completion.
- Reset mid-operation (READ/WRITE/HALT): returns to IDLE next edge with all reset values. A pending stream transfer is abandoned with no handshake completion.
- `in_valid` high outside READ: ignored, no consumption. `out_ready` outside WRITE: ignored.
- Back-to-back SYSCALLs: a request can be accepted in the same cycle `iobusy` is first seen low.

## Structure
- Shared package (with controller constants): syscall codes SYS_HALT=0, SYS_READ=1, SYS_WRITE=2, SYS_CYCLES=3; io state encodings.
- Sub-module: `cycle_counter` (WIDTH-bit free-running wrap counter with synchronous active-low clear). Everything else is in `io_unit`.

## Test plan
- Reset then idle: all outputs at reset values. Counter reads 5 via CYCLES issued at cycle 5 after reset release.
- READ, acc=1, in_valid already high with in_data=16'h1234: in_ready high for exactly 1 cycle, iobusy high 1 cycle, io_result=16'h1234.
- WRITE, acc=2, dr=16'hBEEF, out_ready low 3 cycles then high: out_valid/out_data=16'hBEEF for 4 cycles, iobusy high 4 cycles, then io_result=16'h0002.
- HALT, acc=16'hFFFC (code 0): halted=1, iobusy=1 indefinitely. Runio pulses are ignored. Reset low for one edge clears both.
- Reset asserted during READ with in_valid low: next cycle IDLE, in_ready=0, iobusy=0. A later in_valid is not consumed.
- Counter wrap: after 65536 cycles, CYCLES returns 0 (counter rolls over from 16'hFFFF).
